// File: rtl/axi_lite_read_slave_if.sv
// AXI4-Lite read channel (AR/R) bundle shared by the read responder and its master.
interface axi_lite_read_slave_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  ARVALID;
  logic                  ARREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [2:0]            ARPROT;
  logic                  RVALID;
  logic                  RREADY;
  logic [31:0]           RDATA;
  logic [1:0]            RRESP;

  modport master (
    output ARVALID, ARADDR, ARPROT, RREADY,
    input  ARREADY, RVALID, RDATA, RRESP
  );

  modport slave (
    input  ARVALID, ARADDR, ARPROT, RREADY,
    output ARREADY, RVALID, RDATA, RRESP
  );
endinterface

// File: rtl/axi_lite_read_slave.sv
// AXI4-Lite read responder for a locally loaded register bank; R follows AR by one cycle, one read in flight,
// RDATA/RRESP held until RREADY. Define ALIGN_CHECK_EN to answer misaligned hits with SLVERR.
module axi_lite_read_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [31:0]           RESET_VAL  = '0
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  axi_lite_read_slave_if.slave        bus,
  input  logic                        LW_EN,
  input  logic [$clog2(NUM_REGS)-1:0] LW_IDX,
  input  logic [31:0]                 LW_DATA
);

  localparam int                    IDX_W  = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] REGION = ADDR_WIDTH'(NUM_REGS * 4);
  localparam logic [1:0]            RESP_OKAY   = 2'b00;
  localparam logic [1:0]            RESP_SLVERR = 2'b10;

  typedef enum logic {IDLE, RESP} state_t;

  state_t      state_q, state_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];

  logic [ADDR_WIDTH-1:0] off;
  logic [IDX_W-1:0]      idx;
  logic                  hit;
  logic                  misalign;
  logic                  unused_arprot;

  assign unused_arprot = ^bus.ARPROT;

  always_comb begin
    off = bus.ARADDR - BASE_ADDR;
    hit = (bus.ARADDR >= BASE_ADDR) && (off < REGION);
    idx = off[2 +: IDX_W];
`ifdef ALIGN_CHECK_EN
    misalign = (bus.ARADDR[1:0] != 2'b00);
`else
    misalign = 1'b0;
`endif
  end

  always_comb begin
    state_d   = state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    regs_d    = regs_q;

    // The response samples regs_q, so a same-edge local write is not visible to it.
    if (LW_EN) begin
      regs_d[LW_IDX] = LW_DATA;
    end

    case (state_q)
      IDLE: begin
        arready_d = 1'b1;
        if (bus.ARVALID && arready_q) begin
          state_d   = RESP;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          if (hit && !misalign) begin
            rdata_d = regs_q[idx];
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end
        end
      end
      RESP: begin
        if (bus.RREADY) begin
          state_d   = IDLE;
          arready_d = 1'b1;
          rvalid_d  = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        arready_d = 1'b1;
        rvalid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      regs_q    <= '{default: RESET_VAL};
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      regs_q    <= regs_d;
    end
  end

  assign bus.ARREADY = arready_q;
  assign bus.RVALID  = rvalid_q;
  assign bus.RDATA   = rdata_q;
  assign bus.RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_lite_read_slave.sv
// Directed bench for axi_lite_read_slave: two instances, base 0x000 and base 0x100.
module tb_axi_lite_read_slave;

  logic        ACLK;
  logic        ARESET;
  logic        lw_en0, lw_en1;
  logic [3:0]  lw_idx0, lw_idx1;
  logic [31:0] lw_data0, lw_data1;

  int checks   = 0;
  int failures = 0;

  axi_lite_read_slave_if #(.ADDR_WIDTH(32)) bus0 ();
  axi_lite_read_slave_if #(.ADDR_WIDTH(32)) bus1 ();

  axi_lite_read_slave #(
    .ADDR_WIDTH(32), .NUM_REGS(16), .BASE_ADDR(32'h0000_0000), .RESET_VAL(32'h0000_0000)
  ) dut0 (
    .ACLK(ACLK), .ARESET(ARESET), .bus(bus0.slave),
    .LW_EN(lw_en0), .LW_IDX(lw_idx0), .LW_DATA(lw_data0)
  );

  axi_lite_read_slave #(
    .ADDR_WIDTH(32), .NUM_REGS(16), .BASE_ADDR(32'h0000_0100), .RESET_VAL(32'h0BAD_F00D)
  ) dut1 (
    .ACLK(ACLK), .ARESET(ARESET), .bus(bus1.slave),
    .LW_EN(lw_en1), .LW_IDX(lw_idx1), .LW_DATA(lw_data1)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Single read with RREADY high; inputs driven and outputs sampled on the falling edge.
  task automatic do_read(input int sel, input logic [31:0] addr,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp, input string tag);
    logic        ar_rdy, r_vld;
    logic [31:0] r_dat;
    logic [1:0]  r_resp;
    @(negedge ACLK);
    if (sel == 0) begin
      bus0.RREADY = 1'b1; bus0.ARADDR = addr; bus0.ARVALID = 1'b1; ar_rdy = bus0.ARREADY;
    end else begin
      bus1.RREADY = 1'b1; bus1.ARADDR = addr; bus1.ARVALID = 1'b1; ar_rdy = bus1.ARREADY;
    end
    chk({tag, "_arready"}, 64'(ar_rdy), 64'd1);
    @(negedge ACLK);
    if (sel == 0) begin
      bus0.ARVALID = 1'b0; r_vld = bus0.RVALID; r_dat = bus0.RDATA; r_resp = bus0.RRESP;
    end else begin
      bus1.ARVALID = 1'b0; r_vld = bus1.RVALID; r_dat = bus1.RDATA; r_resp = bus1.RRESP;
    end
    chk({tag, "_rvalid"}, 64'(r_vld), 64'd1);
    chk({tag, "_rdata"},  64'(r_dat), 64'(exp_data));
    chk({tag, "_rresp"},  64'(r_resp), 64'(exp_resp));
    @(negedge ACLK);
    r_vld = (sel == 0) ? bus0.RVALID : bus1.RVALID;
    chk({tag, "_rvalid_done"}, 64'(r_vld), 64'd0);
  endtask

  initial begin
    ARESET = 1'b1;
    lw_en0 = 1'b0; lw_idx0 = '0; lw_data0 = '0;
    lw_en1 = 1'b0; lw_idx1 = '0; lw_data1 = '0;
    bus0.ARVALID = 1'b0; bus0.ARADDR = '0; bus0.ARPROT = 3'b010; bus0.RREADY = 1'b1;
    bus1.ARVALID = 1'b0; bus1.ARADDR = '0; bus1.ARPROT = 3'b000; bus1.RREADY = 1'b1;

    // Reset state
    @(negedge ACLK);
    chk("rst_arready", 64'(bus0.ARREADY), 64'd1);
    chk("rst_rvalid",  64'(bus0.RVALID),  64'd0);
    chk("rst_rdata",   64'(bus0.RDATA),   64'd0);
    chk("rst_rresp",   64'(bus0.RRESP),   64'd0);
    ARESET = 1'b0;

    // Basic read after a local write
    @(negedge ACLK);
    lw_en0 = 1'b1; lw_idx0 = 4'd3; lw_data0 = 32'hDEAD_BEEF;
    @(negedge ACLK);
    lw_en0 = 1'b1; lw_idx0 = 4'd1; lw_data0 = 32'h1111_0001;
    @(negedge ACLK);
    lw_en0 = 1'b0;
    do_read(0, 32'h0000_000C, 32'hDEAD_BEEF, 2'b00, "t1");

    // Backpressure: response held for 5 cycles, second AR waits
    @(negedge ACLK);
    bus0.RREADY = 1'b0; bus0.ARADDR = 32'h0000_0004; bus0.ARVALID = 1'b1;
    @(negedge ACLK);
    bus0.ARADDR = 32'h0000_000C;
    // Local write during the held response must not disturb RDATA
    lw_en0 = 1'b1; lw_idx0 = 4'd1; lw_data0 = 32'h2222_0002;
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_rvalid",  64'(bus0.RVALID),  64'd1);
      chk("t2_hold_rdata",   64'(bus0.RDATA),   64'h1111_0001);
      chk("t2_hold_rresp",   64'(bus0.RRESP),   64'd0);
      chk("t2_hold_arready", 64'(bus0.ARREADY), 64'd0);
      @(negedge ACLK);
      lw_en0 = 1'b0;
    end
    bus0.RREADY = 1'b1;
    @(negedge ACLK);
    chk("t2_hs_rvalid",  64'(bus0.RVALID),  64'd0);
    chk("t2_hs_arready", 64'(bus0.ARREADY), 64'd1);
    @(negedge ACLK);
    chk("t2_second_rvalid",  64'(bus0.RVALID),  64'd1);
    chk("t2_second_rdata",   64'(bus0.RDATA),   64'hDEAD_BEEF);
    chk("t2_second_arready", 64'(bus0.ARREADY), 64'd0);
    bus0.ARVALID = 1'b0;
    @(negedge ACLK);
    chk("t2_second_done", 64'(bus0.RVALID), 64'd0);

    // Decode misses and the offset base
    do_read(0, 32'h0000_0040, 32'h0, 2'b10, "t3_oob");
    do_read(0, 32'h0000_003C, 32'h0, 2'b00, "t3_last");
    do_read(1, 32'h0000_00FC, 32'h0, 2'b10, "t3_below_base");
    do_read(1, 32'h0000_0104, 32'h0BAD_F00D, 2'b00, "t3_base_hit");
    do_read(1, 32'h0000_0140, 32'h0, 2'b10, "t3_base_oob");

    // Same-edge local write and AR accept return the old value
    @(negedge ACLK);
    lw_en0 = 1'b1; lw_idx0 = 4'd5; lw_data0 = 32'h0000_0001;
    @(negedge ACLK);
    lw_data0 = 32'h0000_0002; bus0.ARADDR = 32'h0000_0014; bus0.ARVALID = 1'b1;
    @(negedge ACLK);
    lw_en0 = 1'b0; bus0.ARVALID = 1'b0;
    chk("t4_rvalid", 64'(bus0.RVALID), 64'd1);
    chk("t4_rdata",  64'(bus0.RDATA),  64'd1);
    @(negedge ACLK);
    chk("t4_done", 64'(bus0.RVALID), 64'd0);
    do_read(0, 32'h0000_0014, 32'h0000_0002, 2'b00, "t4_new");

    // Unaligned address
`ifdef ALIGN_CHECK_EN
    do_read(0, 32'h0000_0006, 32'h0, 2'b10, "t6_unaligned");
`else
    do_read(0, 32'h0000_0006, 32'h2222_0002, 2'b00, "t6_unaligned");
`endif

    // Asynchronous reset with a response pending
    @(negedge ACLK);
    bus0.RREADY = 1'b0; bus0.ARADDR = 32'h0000_000C; bus0.ARVALID = 1'b1;
    @(negedge ACLK);
    bus0.ARVALID = 1'b0;
    chk("t5_pending", 64'(bus0.RVALID), 64'd1);
    #2 ARESET = 1'b1;
    #1;
    chk("t5_async_rvalid",  64'(bus0.RVALID),  64'd0);
    chk("t5_async_arready", 64'(bus0.ARREADY), 64'd1);
    @(negedge ACLK);
    ARESET = 1'b0; bus0.RREADY = 1'b1;
    do_read(0, 32'h0000_0000, 32'h0, 2'b00, "t5_reg0");
    do_read(0, 32'h0000_000C, 32'h0, 2'b00, "t5_reg3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
